inv_sub_bytes: RTL
==================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 SHALL have parameter: WIDTH, 128, state width in bits; a multiple of 8 in the range 8..128.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: b  input  WIDTH  input state; byte i is b[8i+7:8i].
REQ-006 SHALL have port: b_isb  output  WIDTH  InvSubBytes result, registered.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: busy  output  1  high from start acceptance until done is asserted.

Function
REQ-009 SHALL compute b_isb byte i = InvSBox(b byte i), per FIPS-197 5.3.2, for every i.
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE; any illegal encoding SHALL go to IDLE.
REQ-011 On start=1 in IDLE, SHALL capture b into an internal register, clear idx and the result accumulator, set busy=1 and go to RUN; b is don't-care after the accepting edge.
REQ-012 In RUN, SHALL substitute exactly one byte per cycle, in ascending index order from byte 0, taken from the captured copy.
REQ-013 SHALL go from RUN to DONE on the edge that processes byte WIDTH/8-1.
REQ-014 In DONE, SHALL load b_isb from the accumulator, set done=1, clear busy and return to IDLE.
REQ-015 SHALL clear done on the next edge, giving a pulse exactly 1 cycle wide.
REQ-016 Latency: done SHALL rise on the (WIDTH/8+1)th rising edge after the accepting edge, i.e. edge 17 for WIDTH=128.
REQ-017 SHALL ignore start while in RUN or DONE; no queuing, no restart.
REQ-018 SHALL accept start=1 during the done-high cycle (IDLE) as a new request; back-to-back throughput is one result per WIDTH/8+2 cycles.
REQ-019 b_isb SHALL hold its value until the next DONE state; it SHALL NOT change during RUN.
REQ-020 The idx counter SHALL be ceil(log2(WIDTH/8)) bits, minimum 1, and SHALL NOT wrap within one operation.

Reset
REQ-021 On rst_n=0, SHALL immediately set b_isb=0, done=0, busy=0, idx=0, accumulator=0, captured state=0 and FSM=IDLE.
REQ-022 Reset mid-operation SHALL abandon the operation and produce no done pulse.
REQ-023 After rst_n deasserts, a start sampled on the first rising edge SHALL be accepted.

Configuration
REQ-024 Macro INV_SUB_BYTES_COMB_EN defined: the per-byte InvSBox SHALL be computed combinationally as the inverse affine transform (rotl1^rotl3^rotl6 of x, xor 0x05) followed by GF(2^8) inversion modulo 0x11B, with 0 mapping to 0.
REQ-025 Macro INV_SUB_BYTES_COMB_EN undefined: the per-byte InvSBox SHALL be a 256x8 ROM initialised from aes_inv_sbox.mem.
REQ-026 Cycle timing and all outputs SHALL be identical in both configurations.

Structure
REQ-027 Package aes_pkg SHALL hold the FSM state typedef, AES_BYTE_W=8, INV_AFFINE_C=8'h05 and SBOX_C=8'h63.
REQ-028 Sub-module aes_gf_inv (8-bit combinational GF(2^8) inverse) SHALL be instantiated only under INV_SUB_BYTES_COMB_EN.

Verification
REQ-029 Directed test: b=all bytes 0x63, start pulse -> b_isb=all 0x00, done at edge 17, busy high for 17 cycles.
REQ-030 Directed test: b=0x00_16_7C_63 in the low 4 bytes, remaining bytes 0x52 -> low bytes 0x52_FF_01_00, remaining bytes 0x48.
REQ-031 Directed test: round trip of random b through sub_bytes then inv_sub_bytes -> b_isb==b, 1000 vectors, run in both macro configurations.
REQ-032 Directed test: start held high for 40 cycles -> exactly two done pulses, at edges 17 and 35; b changed at edge 5 does not corrupt the first result.
REQ-033 Directed test: rst_n asserted at edge 8 of an operation -> all outputs 0 at once, no done pulse; a new start after release completes normally.
REQ-034 Directed test: exhaustive sweep of all 256 byte values in every byte lane (WIDTH=128 and WIDTH=8) against a reference-model InvSBox -> zero mismatches.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: InvSubBytes FSM state, byte constants, GF(2^8) helpers
// and the inverse S-box ROM contents.
package aes_pkg;

  localparam int         AES_BYTE_W   = 8;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;
  localparam logic [7:0] SBOX_C       = 8'h63;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } isb_state_e;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ INV_AFFINE_C;
  endfunction

  // Forward affine step, kept beside its inverse for SubBytes users.
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ SBOX_C;
  endfunction

  localparam logic [7:0] INV_SBOX_ROM [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_gf_inv.sv
// Combinational GF(2^8) inverse as a^254 (0 maps to 0); only present when
// INV_SUB_BYTES_COMB_EN selects the arithmetic InvSBox.
`ifdef INV_SUB_BYTES_COMB_EN
module aes_gf_inv
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] inv_o
);

  logic [7:0] pw;
  logic [7:0] acc;

  // a^254 = a^2 * a^4 * ... * a^128
  always_comb begin
    pw  = gf_mul(a_i, a_i);
    acc = pw;
    for (int k = 0; k < 6; k++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
  end

  assign inv_o = acc;

endmodule
`endif

// File: rtl/inv_sub_bytes.sv
// Byte-serial InvSubBytes: captures the state, substitutes one byte per cycle and
// publishes the result on DONE. INV_SUB_BYTES_COMB_EN selects arithmetic InvSBox over ROM.
//
// state   | meaning
// IDLE    | waiting for start; done pulse (if any) is visible here
// RUN     | substituting byte idx of the captured state
// DONE    | publishing accumulator to b_isb
module inv_sub_bytes
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] b_isb,
  output logic             done,
  output logic             busy
);

  localparam int NB    = WIDTH / AES_BYTE_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  isb_state_e state_q, state_d;

  logic [NB-1:0][7:0] cap_q;
  logic [NB-1:0][7:0] acc_q, acc_d;
  logic [NB-1:0][7:0] b_isb_q;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q;

  logic               accept;
  logic               step;
  logic               publish;
  logic               busy_c;
  logic [7:0]         sbox_in;
  logic [7:0]         sbox_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    step    = 1'b0;
    publish = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      ST_IDLE: accept = start;
      ST_RUN: begin
        step   = 1'b1;
        busy_c = 1'b1;
      end
      ST_DONE: begin
        publish = 1'b1;
        busy_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sbox_in = cap_q[idx_q];

`ifdef INV_SUB_BYTES_COMB_EN
  logic [7:0] aff;
  assign aff = inv_affine(sbox_in);
  aes_gf_inv u_gf_inv (
    .a_i   (aff),
    .inv_o (sbox_out)
  );
`else
  assign sbox_out = INV_SBOX_ROM[sbox_in];
`endif

  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = sbox_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      acc_q   <= '0;
      b_isb_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= publish;
      if (accept) begin
        cap_q <= b;
        acc_q <= '0;
        idx_q <= '0;
      end
      if (step) begin
        acc_q <= acc_d;
        // idx parks on the last byte rather than wrapping
        if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
      end
      if (publish) b_isb_q <= acc_q;
    end
  end

  assign b_isb = b_isb_q;
  assign done  = done_q;
  assign busy  = busy_c;

endmodule
